// File: rtl/idli_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idli_pkg
// Brief    : Shared constants and types for the idli core front end.
// Revision : 1.0
// ============================================================================
package idli_pkg;

    localparam int SQI_NIBBLE_W      = 4;
    localparam int IDLI_WORD_NIBBLES = 4;
    localparam int IDLI_RDBUF_DEPTH  = 2;

    typedef logic [15:0] idli_insn_t;

endpackage
`default_nettype wire

// File: rtl/idli_rdbuf_fifo_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_rdbuf_fifo_m
// Brief    : Generic synchronous FIFO with push/pop, head, count, full/empty.
// Revision : 1.0
// ============================================================================
module idli_rdbuf_fifo_m #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = 1 << PTR_W;

    logic [WIDTH-1:0] r_mem [MEM_N];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_rd;
    logic             w_wr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd    = i_pop && !o_empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_wr    = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/idli_sqi_rdbuf_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_rdbuf_m
// Brief    : SQI nibble assembler feeding a word FIFO toward instruction decode.
// Revision : 1.0
// ============================================================================
module idli_sqi_rdbuf_m
    import idli_pkg::*;
#(
    parameter  int NIBBLES   = IDLI_WORD_NIBBLES,
    parameter  int DEPTH     = IDLI_RDBUF_DEPTH,
    parameter  int LSN_FIRST = 1,
    localparam int W         = SQI_NIBBLE_W * NIBBLES,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    i_rdb_gck,
    input  logic                    i_rdb_rst,
    input  logic                    i_rdb_flush,
    input  logic [SQI_NIBBLE_W-1:0] i_rdb_sqi_data,
    input  logic                    i_rdb_sqi_vld,
    output logic [W-1:0]            o_rdb_word,
    output logic                    o_rdb_word_vld,
    input  logic                    i_rdb_word_acp,
    output logic [CNT_W-1:0]        o_rdb_count,
    output logic                    o_rdb_rdy,
    output logic                    o_rdb_ovf
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_asm;
    logic             r_ovf;
    logic [IDX_W-1:0] w_slot;
    logic [W-1:0]     w_word;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_slot = (LSN_FIRST != 0) ? r_idx : (IDX_W'(NIBBLES - 1) - r_idx);
    assign w_last = i_rdb_sqi_vld && (r_idx == IDX_W'(NIBBLES - 1));
    assign w_push = w_last && !i_rdb_flush;
    assign w_pop  = i_rdb_word_acp && !w_empty;

    // Completed word includes the current nibble so it enters the FIFO this edge.
    always_comb begin
        w_word = r_asm;
        for (int s = 0; s < NIBBLES; s++) begin
            if (w_slot == IDX_W'(s)) begin
                w_word[SQI_NIBBLE_W*s +: SQI_NIBBLE_W] = i_rdb_sqi_data;
            end
        end
    end

    always_ff @(posedge i_rdb_gck) begin
        if (i_rdb_rst || i_rdb_flush) begin
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_rdb_sqi_vld) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            if (w_last && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Slots are rewritten before every push, so the assembly register needs no reset.
    always_ff @(posedge i_rdb_gck) begin
        if (i_rdb_sqi_vld && !i_rdb_flush) begin
            r_asm <= w_word;
        end
    end

    idli_rdbuf_fifo_m #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_rdb_gck),
        .rst     (i_rdb_rst),
        .i_clr   (i_rdb_flush),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (i_rdb_word_acp),
        .o_head  (o_rdb_word),
        .o_count (o_rdb_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_rdb_word_vld = !w_empty;
    assign o_rdb_rdy      = !w_full;
    assign o_rdb_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: doc/idli_sqi_rdbuf_m.md
Name: idli_sqi_rdbuf_m

Overview:
- Parametrised read-data buffer between the SQI memory data pins and instruction decode.
- Captures nibbles tagged valid by control and assembles them into words of NIBBLES nibbles.
- Queues completed words in a DEPTH-entry FIFO and presents them to the consumer on a valid/accept handshake.
- Supports flush on PC redirect and flags overflow when a word completes with no free slot.

Parameters:
NIBBLES, 4, nibbles per assembled word; word width W = 4*NIBBLES; legal range 1..8.
DEPTH, 2, FIFO depth in words; legal range 1..8.
LSN_FIRST, 1, 1: first nibble received lands in word[3:0]; 0: first nibble lands in word[W-1:W-4].

Ports:
i_rdb_gck  in  1  clock; all state updates on rising edge.
i_rdb_rst  in  1  synchronous reset, active-high.
i_rdb_flush  in  1  discard partial word, FIFO contents and overflow flag.
i_rdb_sqi_data  in  4  nibble from SQI memory.
i_rdb_sqi_vld  in  1  nibble valid; captured on this cycle's rising edge.
o_rdb_word  out  W  head-of-FIFO word.
o_rdb_word_vld  out  1  FIFO non-empty.
i_rdb_word_acp  in  1  consumer accepts head word this cycle.
o_rdb_count  out  $clog2(DEPTH+1)  number of complete words held.
o_rdb_rdy  out  1  count < DEPTH; control uses it to pause SQI transfers.
o_rdb_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (i_rdb_rst high at an edge): nibble index, count, read and write pointers and ovf all go to 0. Outputs then read o_rdb_word_vld=0, o_rdb_count=0, o_rdb_rdy=1, o_rdb_ovf=0. o_rdb_word is don't-care while vld=0; the bench does not check it.
- Assembly: a nibble index counter runs 0..NIBBLES-1.
  - Each cycle with sqi_vld, the nibble is written into the assembly register at slot idx. With LSN_FIRST=1, slot idx is bits [4*idx+3:4*idx]; otherwise the slot is mirrored.
  - The index then increments.
  - On idx==NIBBLES-1 the index wraps to 0 and the completed word, including this nibble, is pushed. Data is muxed directly into the FIFO write, so there is no extra cycle.
- Latency: if the last nibble is valid in cycle N, o_rdb_word_vld is high in cycle N+1 with that word at the head. There is no combinational path from sqi_vld or sqi_data to any output.
- Pop: occurs when word_vld && word_acp. An accept with vld=0 is ignored and produces no underflow.
- Simultaneous push and pop:
  - Allowed at any count, including count==DEPTH; count is unchanged.
  - When count==0, a push and an accept in the same cycle pop nothing; the pushed word appears next cycle.
- Overflow: a push with count==DEPTH and no same-cycle pop drops the word. ovf sets and stays set until reset or flush; FIFO contents are unchanged. A partial word is never an overflow.
- o_rdb_rdy is registered-equivalent, decoded from count only; it does not depend on word_acp.
- Flush: has the same effect as reset on idx, count, pointers and ovf. It has priority over a same-cycle nibble, push and pop, and the same-cycle nibble is discarded. Words accepted in the flush cycle count as consumed by the consumer; the buffer asserts nothing further.
- Reset has priority over flush.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap is explicit compare-to-(DEPTH-1).
- Count width: $clog2(DEPTH+1). With DEPTH=1 it is 1 bit.

Decomposition:
- idli_pkg gains the shared constants:
  - SQI_NIBBLE_W = 4.
  - Default word nibbles IDLI_WORD_NIBBLES = 4.
  - IDLI_RDBUF_DEPTH = 2.
  - A typedef for the 16-bit instruction word.
- One sub-module, idli_rdbuf_fifo_m: a generic synchronous FIFO parametrised by width and depth. Its ports are push/data, pop, head, count and full/empty, with sync active-high reset and a clear input.
- The assembler, overflow logic and flush sequencing stay in idli_sqi_rdbuf_m.

Test Plan:
- Defaults, no acp. Nibbles 1,2,3,4 on consecutive cycles → word 0x4321 and word_vld high one cycle after nibble 4. Repeat with LSN_FIRST=0 → 0x1234.
- Defaults, acp held low. Stream 12 nibbles (3 words) → count reaches 2 and rdy drops. The third word is dropped and ovf=1. The two heads pop in order 0x4321 then 0x8765.
- Full FIFO (count=2). Last nibble of a new word arrives in the same cycle as acp → no overflow. count stays 2 and the new word emerges third.
- Two nibbles into a partial word, then flush together with a nibble → idx=0, count=0, ovf=0. The next 4 nibbles A,B,C,D give 0xDCBA.
- Reset asserted mid-word with count=1 → all outputs take their reset values on the next cycle. No stale word appears.
- NIBBLES=1, DEPTH=1. Continuous sqi_vld with acp every cycle → one word per cycle and ovf never sets. Drop acp for one cycle → ovf sets on the second push.
